// File: rtl/write_back_stage_p_if.sv
// write_back_stage_p_if: MEM->WB stage bus (MEM-side inputs, hazard controls, WB-side outputs)
interface write_back_stage_p_if #(
  parameter int XLEN = 32,
  parameter int REG_ADDR_W = 5,
  parameter int WB_SEL_W = 2
);
  logic                  stall_w;
  logic                  flush_w;
  logic                  valid_m;
  logic                  reg_write_m;
  logic [WB_SEL_W-1:0]   write_back_m;
  logic [2:0]            funct3_m;
  logic [XLEN-1:0]       alu_out_m;
  logic [XLEN-1:0]       mem_data_m;
  logic [XLEN-1:0]       pc4_m;
  logic [REG_ADDR_W-1:0] rd_m;
  logic [XLEN-1:0]       write_back_result;
  logic                  reg_write;
  logic [REG_ADDR_W-1:0] rd_w_out;
  logic                  valid_w;
  modport master (
    output stall_w, flush_w, valid_m, reg_write_m, write_back_m, funct3_m,
           alu_out_m, mem_data_m, pc4_m, rd_m,
    input  write_back_result, reg_write, rd_w_out, valid_w
  );
  modport slave (
    input  stall_w, flush_w, valid_m, reg_write_m, write_back_m, funct3_m,
           alu_out_m, mem_data_m, pc4_m, rd_m,
    output write_back_result, reg_write, rd_w_out, valid_w
  );
endinterface

// File: rtl/write_back_stage_p.sv
// write_back_stage_p: registered MEM/WB stage with load extraction and write-back select; WB_RETIRE_CNT_EN adds the instret counter
module write_back_stage_p #(
  parameter int XLEN = 32,
  parameter int REG_ADDR_W = 5,
  parameter int WB_SEL_W = 2
) (
  input  logic clk,
  input  logic rst,
`ifdef WB_RETIRE_CNT_EN
  output logic [63:0] instret,
`endif
  write_back_stage_p_if.slave bus
);
  logic                  valid_q, reg_write_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic [WB_SEL_W-1:0]   sel_q;
  logic [2:0]            funct3_q;
  logic [XLEN-1:0]       alu_q, mem_q, pc4_q, load_v;
  logic [7:0]            byte_v;
  logic [15:0]           half_v;
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      rd_q        <= '0;
      sel_q       <= '0;
      funct3_q    <= '0;
      alu_q       <= '0;
      mem_q       <= '0;
      pc4_q       <= '0;
    end else if (bus.flush_w) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
    end else if (!bus.stall_w) begin
      valid_q     <= bus.valid_m;
      reg_write_q <= bus.reg_write_m;
      rd_q        <= bus.rd_m;
      sel_q       <= bus.write_back_m;
      funct3_q    <= bus.funct3_m;
      alu_q       <= bus.alu_out_m;
      mem_q       <= bus.mem_data_m;
      pc4_q       <= bus.pc4_m;
    end
  end
`ifdef WB_RETIRE_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) instret <= '0;
    else if (!bus.flush_w && !bus.stall_w && bus.valid_m) instret <= instret + 64'd1;
  end
`endif
  // Halfword lane uses only addr[1]; misalignment within a halfword is ignored
  assign byte_v = mem_q[{alu_q[1:0], 3'b000} +: 8];
  assign half_v = mem_q[{alu_q[1], 4'b0000} +: 16];
  always_comb begin
    load_v = funct3_q == 3'b000 ? {{(XLEN-8){byte_v[7]}}, byte_v} :
             funct3_q == 3'b100 ? {{(XLEN-8){1'b0}}, byte_v} :
             funct3_q == 3'b001 ? {{(XLEN-16){half_v[15]}}, half_v} :
             funct3_q == 3'b101 ? {{(XLEN-16){1'b0}}, half_v} : mem_q;
    bus.write_back_result = sel_q == WB_SEL_W'(0) ? alu_q :
                            sel_q == WB_SEL_W'(1) ? load_v :
                            sel_q == WB_SEL_W'(2) ? pc4_q : '0;
    bus.reg_write = valid_q & reg_write_q & (rd_q != '0);
    bus.rd_w_out  = rd_q;
    bus.valid_w   = valid_q;
  end
endmodule
